uart_frame_loader: RTL and testbench

Downstream neighbour of the UART receiver in the bitonic-sort path. Collects the received byte stream into a fixed-size frame of `N_BYTES` slots and hands the complete frame to the sorter over a valid/ready handshake. A frame closes when the receiver's end-of-data strobe arrives. Unused slots are padded so they sort to the tail in an ascending sort.

---
 rtl/uart_frame_loader.sv | 98 +++++++++
 tb/tb_uart_frame_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_loader.sv
// uart_frame_loader
// Gathers the UART byte stream into a fixed frame of N_BYTES slots, pads the
// unused tail with PAD_BYTE and offers the finished frame to the bitonic
// sorter over a valid/ready handshake. A frame closes on the end-of-data byte.
module uart_frame_loader #(
  parameter int          N_BYTES  = 8,
  parameter logic [7:0]  PAD_BYTE = 8'hFF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  input  logic                         in_end,
  output logic [8*N_BYTES-1:0]         frame_data,
  output logic [$clog2(N_BYTES+1)-1:0] frame_count,
  output logic                         frame_overflow,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic                         rx_dropped
);

  localparam int CW = $clog2(N_BYTES + 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                r_state;
  logic [8*N_BYTES-1:0]  r_frame_data;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;
  logic                  r_frame_overflow;
  logic                  r_valid;
  logic                  r_dropped;

  // Collect bytes into slots, close the frame on the terminator and hold it
  // untouched until the sorter takes it; the transfer restores the pad bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= COLLECT;
      r_frame_data     <= {N_BYTES{PAD_BYTE}};
      r_count          <= '0;
      r_ovf            <= 1'b0;
      r_frame_overflow <= 1'b0;
      r_valid          <= 1'b0;
      r_dropped        <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (in_valid) begin
            if (!in_end) begin
              if (r_count < CW'(N_BYTES)) begin
                for (int k = 0; k < N_BYTES; k++) begin
                  if (k == int'(r_count)) begin
                    r_frame_data[8*k +: 8] <= in_data;
                  end
                end
                r_count <= r_count + CW'(1);
              end else begin
                r_ovf <= 1'b1;
              end
            end else if (r_count != '0) begin
              r_state          <= HOLD;
              r_valid          <= 1'b1;
              r_frame_overflow <= r_ovf;
            end else begin
              r_ovf <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (in_valid) begin
            r_dropped <= 1'b1;
          end
          if (frame_ready) begin
            r_state          <= COLLECT;
            r_valid          <= 1'b0;
            r_frame_data     <= {N_BYTES{PAD_BYTE}};
            r_count          <= '0;
            r_ovf            <= 1'b0;
            r_frame_overflow <= 1'b0;
          end
        end
        default: begin
          r_state <= COLLECT;
        end
      endcase
    end
  end

  assign frame_data     = r_frame_data;
  assign frame_count    = r_count;
  assign frame_overflow = r_frame_overflow;
  assign frame_valid    = r_valid;
  assign rx_dropped     = r_dropped;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Directed self-checking bench for uart_frame_loader with N_BYTES=8 and the
// default 0xFF pad byte.
module tb_uart_frame_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_end;
  logic [63:0] frame_data;
  logic [3:0]  frame_count;
  logic        frame_overflow;
  logic        frame_valid;
  logic        frame_ready;
  logic        rx_dropped;

  int assertCount = 0;
  int failCount   = 0;

  uart_frame_loader #(
    .N_BYTES  (8),
    .PAD_BYTE (8'hFF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_end         (in_end),
    .frame_data     (frame_data),
    .frame_count    (frame_count),
    .frame_overflow (frame_overflow),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .rx_dropped     (rx_dropped)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Present one byte for a single clock and return 1 ns after the sampling edge
  task automatic applyStimulus(input logic [7:0] data, input logic isEnd);
    in_data  = data;
    in_valid = 1'b1;
    in_end   = isEnd;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_end   = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    in_data     = 8'h00;
    in_valid    = 1'b0;
    in_end      = 1'b0;
    frame_ready = 1'b1;

    #12;
    checkOutput("reset_valid", 64'(frame_valid), 64'h0);
    checkOutput("reset_count", 64'(frame_count), 64'h0);
    checkOutput("reset_data", frame_data, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("reset_ovf", 64'(frame_overflow), 64'h0);
    checkOutput("reset_dropped", 64'(rx_dropped), 64'h0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Short frame 05 01 09 closed by 03
    applyStimulus(8'h05, 1'b0);
    checkOutput("write_slot0", 64'(frame_data[7:0]), 64'h05);
    checkOutput("write_count1", 64'(frame_count), 64'h1);
    checkOutput("write_nvalid", 64'(frame_valid), 64'h0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h09, 1'b0);
    applyStimulus(8'h03, 1'b1);
    checkOutput("short_valid", 64'(frame_valid), 64'h1);
    checkOutput("short_count", 64'(frame_count), 64'h3);
    checkOutput("short_data", frame_data, 64'hFFFF_FFFF_FF09_0105);
    checkOutput("short_ovf", 64'(frame_overflow), 64'h0);
    idleCycles(1);
    checkOutput("short_valid_drop", 64'(frame_valid), 64'h0);
    checkOutput("short_pad_restore", frame_data, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("short_count_clear", 64'(frame_count), 64'h0);

    // Exactly full frame 10..17
    for (int i = 0; i < 8; i++) applyStimulus(8'h10 + 8'(i), 1'b0);
    applyStimulus(8'hEE, 1'b1);
    checkOutput("full_valid", 64'(frame_valid), 64'h1);
    checkOutput("full_count", 64'(frame_count), 64'h8);
    checkOutput("full_data", frame_data, 64'h1716_1514_1312_1110);
    checkOutput("full_ovf", 64'(frame_overflow), 64'h0);
    idleCycles(1);

    // Overflowing frame 20..29
    for (int i = 0; i < 10; i++) applyStimulus(8'h20 + 8'(i), 1'b0);
    checkOutput("ovf_count_sat", 64'(frame_count), 64'h8);
    applyStimulus(8'hEE, 1'b1);
    checkOutput("ovf_valid", 64'(frame_valid), 64'h1);
    checkOutput("ovf_count", 64'(frame_count), 64'h8);
    checkOutput("ovf_data", frame_data, 64'h2726_2524_2322_2120);
    checkOutput("ovf_flag", 64'(frame_overflow), 64'h1);
    idleCycles(1);
    checkOutput("ovf_flag_clear", 64'(frame_overflow), 64'h0);
    applyStimulus(8'h55, 1'b0);
    applyStimulus(8'hEE, 1'b1);
    checkOutput("after_ovf_valid", 64'(frame_valid), 64'h1);
    checkOutput("after_ovf_flag", 64'(frame_overflow), 64'h0);
    checkOutput("after_ovf_data", frame_data, 64'hFFFF_FFFF_FFFF_FF55);
    idleCycles(1);

    // Terminator alone yields no frame
    applyStimulus(8'hEE, 1'b1);
    checkOutput("empty_valid0", 64'(frame_valid), 64'h0);
    idleCycles(1);
    checkOutput("empty_valid1", 64'(frame_valid), 64'h0);
    applyStimulus(8'h77, 1'b0);
    applyStimulus(8'hEE, 1'b1);
    checkOutput("one_valid", 64'(frame_valid), 64'h1);
    checkOutput("one_count", 64'(frame_count), 64'h1);
    checkOutput("one_data", frame_data, 64'hFFFF_FFFF_FFFF_FF77);
    idleCycles(1);

    // Back-pressure: sorter stalls 200 cycles while extra bytes arrive
    frame_ready = 1'b0;
    applyStimulus(8'h42, 1'b0);
    applyStimulus(8'hEE, 1'b1);
    checkOutput("hold_valid_start", 64'(frame_valid), 64'h1);
    checkOutput("hold_dropped_before", 64'(rx_dropped), 64'h0);
    idleCycles(50);
    applyStimulus(8'h33, 1'b0);
    checkOutput("hold_dropped_set", 64'(rx_dropped), 64'h1);
    idleCycles(50);
    applyStimulus(8'h44, 1'b1);
    idleCycles(98);
    checkOutput("hold_valid_end", 64'(frame_valid), 64'h1);
    checkOutput("hold_count", 64'(frame_count), 64'h1);
    checkOutput("hold_data", frame_data, 64'hFFFF_FFFF_FFFF_FF42);
    checkOutput("hold_ovf", 64'(frame_overflow), 64'h0);
    frame_ready = 1'b1;
    idleCycles(1);
    checkOutput("release_valid", 64'(frame_valid), 64'h0);
    checkOutput("release_dropped", 64'(rx_dropped), 64'h1);
    checkOutput("release_pad", frame_data, 64'hFFFF_FFFF_FFFF_FFFF);

    // Reset in the middle of a frame
    applyStimulus(8'hA1, 1'b0);
    applyStimulus(8'hA2, 1'b0);
    checkOutput("pre_rst_count", 64'(frame_count), 64'h2);
    rst_n = 1'b0;
    #2;
    checkOutput("mid_rst_count", 64'(frame_count), 64'h0);
    checkOutput("mid_rst_data", frame_data, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("mid_rst_dropped", 64'(rx_dropped), 64'h0);
    checkOutput("mid_rst_valid", 64'(frame_valid), 64'h0);
    #2;
    rst_n = 1'b1;
    idleCycles(3);
    checkOutput("post_rst_valid", 64'(frame_valid), 64'h0);
    for (int i = 0; i < 4; i++) applyStimulus(8'hB0 + 8'(i), 1'b0);
    applyStimulus(8'hEE, 1'b1);
    checkOutput("fresh_valid", 64'(frame_valid), 64'h1);
    checkOutput("fresh_count", 64'(frame_count), 64'h4);
    checkOutput("fresh_data", frame_data, 64'hFFFF_FFFF_B3B2_B1B0);
    idleCycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
